// File: rtl/bft_pkg.sv
// Shared definitions for the BFT leaf endpoint: direction codes, default
// packet geometry and the VOID packet constant.
package bft_pkg;

  // Same codes as the t-switch direction encodings.
  typedef enum logic [1:0] {
    VOID  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    UP    = 2'b11
  } bft_dir_e;

  localparam int BFT_ADDR_W    = 5;
  localparam int BFT_PAYLOAD_W = 32;
  localparam int BFT_P_W       = 1 + BFT_ADDR_W + BFT_PAYLOAD_W;

  // Packet = {valid, addr, payload}; offsets for the default geometry.
  localparam int BFT_PAYLOAD_LSB = 0;
  localparam int BFT_ADDR_LSB    = BFT_PAYLOAD_W;
  localparam int BFT_VALID_BIT   = BFT_P_W - 1;

  localparam logic [BFT_P_W-1:0] BFT_VOID_PKT = '0;

endpackage

// File: rtl/bft_leaf_fifo.sv
// Synchronous FIFO with async active-high reset. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
// A push while full is accepted only if a pop happens the same cycle.
module bft_leaf_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Accept/advance decisions; full with same-cycle pop still takes the push.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
  end

  // Pointer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/bft_leaf_interface.sv
// PE-side endpoint of the deflection-routed BFT. Injects buffered PE
// packets on the uplink and absorbs downlink packets addressed here,
// bouncing them back up when they cannot be taken.
// Optional feature macro: BFT_LEAF_BOUNCE_CNT_EN (adds bounce_cnt port).
module bft_leaf_interface
  import bft_pkg::*;
#(
  parameter int ADDR_W     = BFT_ADDR_W,
  parameter int PAYLOAD_W  = BFT_PAYLOAD_W,
  parameter int LEAF_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W+PAYLOAD_W-1:0] pe_in_data,
  input  logic                        pe_in_valid,
  output logic                        pe_in_ready,
  output logic [ADDR_W+PAYLOAD_W-1:0] pe_out_data,
  output logic                        pe_out_valid,
  input  logic                        pe_out_ready,
  input  logic [ADDR_W+PAYLOAD_W:0]   tree_in,
  output logic [ADDR_W+PAYLOAD_W:0]   tree_out
`ifdef BFT_LEAF_BOUNCE_CNT_EN
  ,
  output logic [15:0]                 bounce_cnt
`endif
);

  localparam int P_W = 1 + ADDR_W + PAYLOAD_W;
  localparam int D_W = ADDR_W + PAYLOAD_W;

  logic           tx_push, tx_pop, tx_full, tx_empty;
  logic [D_W-1:0] tx_dout;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic           in_valid, addr_hit, bounce;
  logic [P_W-1:0] tree_out_q, tree_out_d;

  assign pe_in_ready  = !tx_full;
  assign pe_out_valid = !rx_empty;
  assign tree_out     = tree_out_q;

  // Downlink handling and uplink selection: bounce > tx head > VOID.
  always_comb begin
    in_valid   = tree_in[P_W-1];
    addr_hit   = (tree_in[P_W-2 -: ADDR_W] == ADDR_W'(LEAF_ADDR));
    tx_push    = pe_in_valid && !tx_full;
    rx_pop     = pe_out_ready && !rx_empty;
    rx_push    = in_valid && addr_hit && (!rx_full || rx_pop);
    bounce     = in_valid && !rx_push;
    tx_pop     = !bounce && !tx_empty;
    tree_out_d = '0;
    if (bounce)      tree_out_d = tree_in;
    else if (tx_pop) tree_out_d = {1'b1, tx_dout};
  end

  // Registered uplink.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tree_out_q <= '0;
    else       tree_out_q <= tree_out_d;
  end

`ifdef BFT_LEAF_BOUNCE_CNT_EN
  logic [15:0] bounce_cnt_q;
  assign bounce_cnt = bounce_cnt_q;

  // Saturating count of bounces from either cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              bounce_cnt_q <= '0;
    else if (bounce && bounce_cnt_q != '1)  bounce_cnt_q <= bounce_cnt_q + 16'd1;
  end
`endif

  bft_leaf_fifo #(.WIDTH(D_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk     (clk),
    .rst     (reset),
    .push_i  (tx_push),
    .din_i   (pe_in_data),
    .pop_i   (tx_pop),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  bft_leaf_fifo #(.WIDTH(D_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk     (clk),
    .rst     (reset),
    .push_i  (rx_push),
    .din_i   (tree_in[D_W-1:0]),
    .pop_i   (rx_pop),
    .dout_o  (pe_out_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

endmodule

// File: tb/tb_bft_leaf_interface.sv
// Directed self-checking bench for bft_leaf_interface (LEAF_ADDR=0, depth 4).
module tb_bft_leaf_interface;

  localparam int ADDR_W = 5;
  localparam int PAYLOAD_W = 32;
  localparam int P_W = 1 + ADDR_W + PAYLOAD_W;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [ADDR_W+PAYLOAD_W-1:0] pe_in_data = '0;
  logic                        pe_in_valid = 1'b0;
  logic                        pe_in_ready;
  logic [ADDR_W+PAYLOAD_W-1:0] pe_out_data;
  logic                        pe_out_valid;
  logic                        pe_out_ready = 1'b0;
  logic [P_W-1:0]              tree_in = '0;
  logic [P_W-1:0]              tree_out;
`ifdef BFT_LEAF_BOUNCE_CNT_EN
  logic [15:0]                 bounce_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bft_leaf_interface #(
    .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W), .LEAF_ADDR(0), .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pe_in_data   (pe_in_data),
    .pe_in_valid  (pe_in_valid),
    .pe_in_ready  (pe_in_ready),
    .pe_out_data  (pe_out_data),
    .pe_out_valid (pe_out_valid),
    .pe_out_ready (pe_out_ready),
    .tree_in      (tree_in),
    .tree_out     (tree_out)
`ifdef BFT_LEAF_BOUNCE_CNT_EN
    ,
    .bounce_cnt   (bounce_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [P_W-1:0] pkt(input logic [ADDR_W-1:0] a, input logic [31:0] p);
    return {1'b1, a, p};
  endfunction

  task automatic test_reset();
    // Power-on reset state.
    checks++; if (tree_out !== '0) begin failures++; $display("FAIL por_tree_out got=%h exp=0", tree_out); end
    checks++; if (pe_out_valid !== 1'b0) begin failures++; $display("FAIL por_out_valid got=%b exp=0", pe_out_valid); end
    checks++; if (pe_in_ready !== 1'b1) begin failures++; $display("FAIL por_in_ready got=%b exp=1", pe_in_ready); end
`ifdef BFT_LEAF_BOUNCE_CNT_EN
    checks++; if (bounce_cnt !== 16'd0) begin failures++; $display("FAIL por_bounce_cnt got=%0d exp=0", bounce_cnt); end
`endif
    reset = 1'b0;
    tick();
    // Half-fill rx (2 entries).
    pe_out_ready = 1'b0;
    tree_in = pkt(5'd0, 32'h0000_0101); tick();
    tree_in = pkt(5'd0, 32'h0000_0102); tick();
    // Half-fill tx while misroutes keep the uplink busy.
    pe_in_valid = 1'b1;
    tree_in = pkt(5'd9, 32'h0000_0201); pe_in_data = {5'd3, 32'h0000_0301}; tick();
    tree_in = pkt(5'd9, 32'h0000_0202); pe_in_data = {5'd3, 32'h0000_0302}; tick();
    pe_in_valid = 1'b0;
    checks++; if (pe_out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_rx got=%b exp=1", pe_out_valid); end
    // Asynchronous reset mid-traffic.
    reset = 1'b1;
    tree_in = '0;
    #1;
    checks++; if (tree_out !== '0) begin failures++; $display("FAIL rst_tree_out got=%h exp=0", tree_out); end
    checks++; if (pe_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", pe_out_valid); end
    checks++; if (pe_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", pe_in_ready); end
    tick();
    reset = 1'b0;
    // No stale packet may surface on either side afterwards.
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (tree_out !== '0 || pe_out_valid !== 1'b0) begin
        failures++; $display("FAIL rst_stale cyc=%0d tree_out=%h out_valid=%b exp=0/0", i, tree_out, pe_out_valid);
      end
    end
  endtask

  task automatic test_inject();
    pe_in_valid = 1'b1; pe_in_data = {5'd5, 32'hA5A5_0001};
    tick();                       // edge k: accepted
    pe_in_valid = 1'b0;
    checks++; if (tree_out !== '0) begin failures++; $display("FAIL inj_k got=%h exp=0", tree_out); end
    tick();                       // edge k+1
    checks++; if (tree_out !== pkt(5'd5, 32'hA5A5_0001)) begin failures++; $display("FAIL inj_k1 got=%h exp=%h", tree_out, pkt(5'd5, 32'hA5A5_0001)); end
    tick();
    checks++; if (tree_out !== '0) begin failures++; $display("FAIL inj_after got=%h exp=0", tree_out); end
  endtask

  task automatic test_deliver();
    pe_out_ready = 1'b1;
    tree_in = pkt(5'd0, 32'h0000_1234);
    tick();
    tree_in = '0;
    checks++; if (pe_out_valid !== 1'b1 || pe_out_data !== {5'd0, 32'h0000_1234}) begin
      failures++; $display("FAIL dlv_data valid=%b data=%h exp=1/%h", pe_out_valid, pe_out_data, {5'd0, 32'h0000_1234});
    end
    checks++; if (tree_out !== '0) begin failures++; $display("FAIL dlv_tree_out got=%h exp=0", tree_out); end
    tick();
    checks++; if (pe_out_valid !== 1'b0) begin failures++; $display("FAIL dlv_drain got=%b exp=0", pe_out_valid); end
  endtask

  task automatic test_rx_full_bounce();
    logic [31:0] exp_q [$];
    pe_out_ready = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      tree_in = pkt(5'd0, 32'(i)); tick();
      exp_q.push_back(32'(i));
    end
    tree_in = pkt(5'd0, 32'hDEAD);
    tick();
    checks++; if (tree_out !== pkt(5'd0, 32'hDEAD)) begin failures++; $display("FAIL rxb_bounce got=%h exp=%h", tree_out, pkt(5'd0, 32'hDEAD)); end
`ifdef BFT_LEAF_BOUNCE_CNT_EN
    checks++; if (bounce_cnt !== 16'd1) begin failures++; $display("FAIL rxb_cnt got=%0d exp=1", bounce_cnt); end
`endif
    // Same full state, but the PE pops that cycle: packet accepted.
    pe_out_ready = 1'b1;
    tree_in = pkt(5'd0, 32'hF00D);
    tick();
    tree_in = '0;
    void'(exp_q.pop_front());
    exp_q.push_back(32'hF00D);
    checks++; if (tree_out !== '0) begin failures++; $display("FAIL rxb_nobounce got=%h exp=0", tree_out); end
`ifdef BFT_LEAF_BOUNCE_CNT_EN
    checks++; if (bounce_cnt !== 16'd1) begin failures++; $display("FAIL rxb_cnt2 got=%0d exp=1", bounce_cnt); end
`endif
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (pe_out_valid !== 1'b1 || pe_out_data !== {5'd0, e}) begin
        failures++; $display("FAIL rxb_order valid=%b data=%h exp=1/%h", pe_out_valid, pe_out_data, {5'd0, e});
      end
      tick();
    end
    checks++; if (pe_out_valid !== 1'b0) begin failures++; $display("FAIL rxb_empty got=%b exp=0", pe_out_valid); end
  endtask

  task automatic test_priority();
    pe_in_valid = 1'b1; pe_in_data = {5'd9, 32'hBEEF};
    tick();
    pe_in_valid = 1'b0;
    tree_in = pkt(5'd7, 32'hCAFE);
    tick();
    tree_in = '0;
    checks++; if (tree_out !== pkt(5'd7, 32'hCAFE)) begin failures++; $display("FAIL pri_bounce got=%h exp=%h", tree_out, pkt(5'd7, 32'hCAFE)); end
    tick();
    checks++; if (tree_out !== pkt(5'd9, 32'hBEEF)) begin failures++; $display("FAIL pri_tx got=%h exp=%h", tree_out, pkt(5'd9, 32'hBEEF)); end
    tick();
    checks++; if (tree_out !== '0) begin failures++; $display("FAIL pri_void got=%h exp=0", tree_out); end
  endtask

  task automatic test_tx_full();
    pe_in_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      pe_in_data = {5'd1, 32'h10 + 32'(i)};
      tree_in = pkt(5'd3, 32'h50 + 32'(i));
      tick();
      checks++; if (tree_out !== pkt(5'd3, 32'h50 + 32'(i))) begin
        failures++; $display("FAIL txf_bounce i=%0d got=%h exp=%h", i, tree_out, pkt(5'd3, 32'h50 + 32'(i)));
      end
    end
    checks++; if (pe_in_ready !== 1'b0) begin failures++; $display("FAIL txf_ready got=%b exp=0", pe_in_ready); end
    // Offer one more while full; it must not be taken.
    pe_in_data = {5'd1, 32'hFF};
    tree_in = pkt(5'd3, 32'h99);
    tick();
    pe_in_valid = 1'b0;
    tree_in = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      checks++; if (tree_out !== pkt(5'd1, 32'h10 + 32'(i))) begin
        failures++; $display("FAIL txf_drain i=%0d got=%h exp=%h", i, tree_out, pkt(5'd1, 32'h10 + 32'(i)));
      end
      if (i == 0) begin
        checks++; if (pe_in_ready !== 1'b1) begin failures++; $display("FAIL txf_ready_back got=%b exp=1", pe_in_ready); end
      end
    end
    tick();
    checks++; if (tree_out !== '0) begin failures++; $display("FAIL txf_void got=%h exp=0", tree_out); end
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_inject();
    test_deliver();
    test_rx_full_bounce();
    test_priority();
    test_tx_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
